fpga_msg_arbiter: RTL

//  Shares the single outbound fpga_msg FIFO write port among N_REQ application requesters.

---
 rtl/fpga_msg_arbiter_pkg.sv | 26 ++
 rtl/fpga_msg_arbiter_rr_pick.sv | 32 +++
 rtl/fpga_msg_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fpga_msg_arbiter_pkg.sv
// Shared definitions for the fpga_msg write-port arbiter: state encodings and
// the width helper used for grant index and tag fields.
`timescale 1ns/1ps

package fpga_msg_arbiter_pkg;

    // Arbiter FSM encodings.
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Burst counter width: MAX_BURST is limited to 255.
    localparam int BURST_W = 8;

    // Ceiling log2, never less than 1 so index vectors always have a bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/fpga_msg_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: scans req starting at ptr,
// wrapping mod N, and returns the first set index.
`timescale 1ns/1ps

module fpga_msg_arbiter_rr_pick
    import fpga_msg_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    // Walk the scan order backwards so the earliest hit is the last assignment.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
        any = 1'b0;
        idx = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            int pos;
            pos = (int'(ptr) + k) % N;
            if (req[pos]) begin
                any = 1'b1;
                idx = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/fpga_msg_arbiter.sv
// fpga_msg_arbiter: shares the single FPGA->PC message FIFO write port among
// N_REQ requesters with round-robin, bounded-burst grants. Requesters that
// drop valid before being acked raise a sticky error.
// Optional build macro FPGA_MSG_ARB_TAG_EN: overwrite the top clog2(N_REQ)
// bits of each written word with the grantee index and flag nonzero tag bits
// from the requester as an error.
`timescale 1ns/1ps

module fpga_msg_arbiter
    import fpga_msg_arbiter_pkg::*;
#(
    parameter int XB_SIZE   = 32,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 8,
    localparam int IDX_W    = clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*XB_SIZE-1:0] req_msg,
    output logic [N_REQ-1:0]         req_ack,
    input  logic                     fpga_msg_full,
    output logic                     fpga_msg_valid,
    output logic [XB_SIZE-1:0]       fpga_msg,
    output logic [IDX_W-1:0]         grant_idx,
    output logic                     error
);

    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_REQ - 1);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [BURST_W-1:0] burst_cnt;
    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic               grant_valid;
    logic [XB_SIZE-1:0] grant_word;
    logic [XB_SIZE-1:0] out_word;
    logic               accept;
    logic               exit_grant;
    logic               tag_bad;
    logic               violation;
    logic [N_REQ-1:0]   prev_valid;
    logic [N_REQ-1:0]   prev_ack;

    fpga_msg_arbiter_rr_pick #(
        .N  (N_REQ),
        .IW (IDX_W)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign grant_valid = req_valid[grant_idx];
    assign grant_word  = req_msg[int'(grant_idx) * XB_SIZE +: XB_SIZE];

`ifdef FPGA_MSG_ARB_TAG_EN
    assign out_word = {grant_idx, grant_word[XB_SIZE-IDX_W-1:0]};
    assign tag_bad  = accept && (grant_word[XB_SIZE-1 -: IDX_W] != '0);
`else
    assign out_word = grant_word;
    assign tag_bad  = 1'b0;
`endif

    // A requester that was valid and unacked last cycle must still be valid now.
    assign violation = |(prev_valid & ~prev_ack & ~req_valid);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave IDLE on any request, leave GRANT on burst end or idle grantee.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (pick_any)   state_nxt = ARB_GRANT;
            ARB_GRANT: if (exit_grant) state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    // Outputs: accept/ack only while granting and the FIFO has room; ack is same-cycle.
    always_comb begin
        accept     = 1'b0;
        req_ack    = '0;
        exit_grant = 1'b0;
        if (state == ARB_GRANT) begin
            accept = grant_valid && !fpga_msg_full;
            if (accept) begin
                req_ack[grant_idx] = 1'b1;
            end
            exit_grant = (accept && (burst_cnt == BURST_LAST)) ||
                         (!grant_valid && !accept);
        end
    end

    // Grant bookkeeping: latch the grantee, count the burst, rotate the pointer on exit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_idx <= '0;
            burst_cnt <= '0;
            rr_ptr    <= '0;
        end else begin
            if (state == ARB_IDLE) begin
                if (pick_any) begin
                    grant_idx <= pick_idx;
                    burst_cnt <= '0;
                end
            end else begin
                if (accept) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
                if (exit_grant) begin
                    rr_ptr <= (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
                end
            end
        end
    end

    // Registered FIFO write port: one strobe per accepted word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpga_msg_valid <= 1'b0;
            fpga_msg       <= '0;
        end else begin
            fpga_msg_valid <= accept;
            if (accept) begin
                fpga_msg <= out_word;
            end
        end
    end

    // Protocol monitor: remember last cycle's valid/ack and hold error until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_valid <= '0;
            prev_ack   <= '0;
            error      <= 1'b0;
        end else begin
            prev_valid <= req_valid;
            prev_ack   <= req_ack;
            if (violation || tag_bad) begin
                error <= 1'b1;
            end
        end
    end

endmodule
